// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: NOP encoding, fault bit indices, imem FSM states.
// IMEM_PARITY_EN widens stored words by one parity bit and the fault vector to 3 bits.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned FAULT_MISALIGN = 0;
  localparam int unsigned FAULT_RANGE    = 1;
  localparam int unsigned FAULT_PARITY   = 2;

`ifdef IMEM_PARITY_EN
  localparam int unsigned PAR_W   = 1;
  localparam int unsigned FAULT_W = 3;
`else
  localparam int unsigned PAR_W   = 0;
  localparam int unsigned FAULT_W = 2;
`endif

  typedef enum logic {
    CLEAR,
    READY
  } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// Single-port RAM, synchronous write, registered read; read register only loads on re
// so the last fetched word stays on rdata while the consumer stalls.
module imem_array #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  parameter logic [WIDTH-1:0] RST_DATA = '0,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= RST_DATA;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch_unit.sv
// Writable instruction memory with self-clearing init, program-load port and a
// valid/ready fetch port with fault reporting. Optional parity: IMEM_PARITY_EN.
module imem_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned      XLEN       = 32,
  parameter int unsigned      DEPTH      = 64,
  parameter logic [31:0]      BASE_ADDR  = 32'h0000_0000,
  parameter logic [XLEN-1:0]  FILL_INSTR = XLEN'(NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               init_done,
  input  logic               load_we,
  input  logic [31:0]        load_addr,
  input  logic [XLEN-1:0]    load_data,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [31:0]        fetch_addr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [XLEN-1:0]    rsp_instr,
  output logic [FAULT_W-1:0] rsp_fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned MW = XLEN + PAR_W;
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
`ifdef IMEM_PARITY_EN
  localparam logic [MW-1:0] FILL_WORD = {^FILL_INSTR, FILL_INSTR};
`else
  localparam logic [MW-1:0] FILL_WORD = FILL_INSTR;
`endif

  // 33-bit compare so ranges ending at the top of the address space never wrap
  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  imem_state_t   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          init_done_q, init_done_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [1:0]    fault_q, fault_d;

  logic          clearing, ready, load_ok, accept, par_err;
  logic [1:0]    f_fault;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [XLEN-1:0] wr_instr;
  logic [MW-1:0] mem_wdata, mem_rdata;

  assign clearing = (state_q == CLEAR);
  assign ready    = (state_q == READY);
  assign load_ok  = ready && load_we && (load_addr[1:0] == 2'b00) && in_range(load_addr);

  assign fetch_ready = ready && !load_we && (!rsp_valid_q || rsp_ready);
  assign accept      = fetch_valid && fetch_ready;

  always_comb begin
    f_fault                 = '0;
    f_fault[FAULT_MISALIGN] = (fetch_addr[1:0] != 2'b00);
    f_fault[FAULT_RANGE]    = !in_range(fetch_addr);
  end

  // Writes (clear/load) and reads never coincide, so one address port serves both
  always_comb begin
    mem_we   = clearing || load_ok;
    mem_re   = accept && (f_fault == 2'b00);
    wr_instr = clearing ? FILL_INSTR : load_data;
    mem_addr = word_idx(fetch_addr);
    if (clearing)     mem_addr = idx_q;
    else if (load_ok) mem_addr = word_idx(load_addr);
  end

`ifdef IMEM_PARITY_EN
  assign mem_wdata = {^wr_instr, wr_instr};
  assign par_err   = (fault_q == 2'b00) && (^mem_rdata);
  assign rsp_fault = {par_err, fault_q};
`else
  assign mem_wdata = wr_instr;
  assign par_err   = 1'b0;
  assign rsp_fault = fault_q;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    case (state_q)
      CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(DEPTH - 1)) state_d = READY;
      end
      READY:   init_done_d = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    fault_d     = fault_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      fault_d     = f_fault;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CLEAR;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      fault_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      fault_q     <= fault_d;
    end
  end

  imem_array #(
    .WIDTH    (MW),
    .DEPTH    (DEPTH),
    .RST_DATA (FILL_WORD)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = ((fault_q != 2'b00) || par_err) ? FILL_INSTR : mem_rdata[XLEN-1:0];

endmodule
